// File: rtl/wb_sys_arbiter.sv
// Two-master to one-slave Wishbone arbiter, round-robin on ties; request in IDLE -> slave strobe one edge later, response one edge after termination.
// Masters wait on m_ack_o/m_err_o; a slave that never answers is cut off after TIMEOUT cycles with an error.
module wb_sys_arbiter #(
   parameter int TIMEOUT  = 1024,
   parameter int TO_CNT_W = 16
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   input  logic [1:0]          m_cyc_i,
   input  logic [1:0]          m_stb_i,
   input  logic [1:0]          m_we_i,
   input  logic [7:0]          m_sel_i,
   input  logic [63:0]         m_adr_i,
   input  logic [63:0]         m_dat_i,
   output logic [31:0]         m_dat_o,
   output logic [1:0]          m_ack_o,
   output logic [1:0]          m_err_o,
   output logic                s_cyc_o,
   output logic                s_stb_o,
   output logic                s_we_o,
   output logic [3:0]          s_sel_o,
   output logic [31:0]         s_adr_o,
   output logic [31:0]         s_dat_o,
   input  logic [31:0]         s_dat_i,
   input  logic                s_ack_i,
   input  logic                s_err_i,
   output logic [1:0]          grant_o,
   output logic [TO_CNT_W-1:0] timeout_cnt_o
);

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   state_t              state_q, state_d;
   logic                last_q, last_d;
   logic [15:0]         to_q, to_d;
   logic [TO_CNT_W-1:0] tcnt_q, tcnt_d;
   logic                s_cyc_q, s_cyc_d, s_stb_q, s_stb_d, s_we_q, s_we_d;
   logic [3:0]          s_sel_q, s_sel_d;
   logic [31:0]         s_adr_q, s_adr_d, s_dat_q, s_dat_d;
   logic [1:0]          grant_q, grant_d, m_ack_q, m_ack_d, m_err_q, m_err_d;
   logic [31:0]         m_dat_q, m_dat_d;

   logic [1:0]          req;
   logic                pick;
   logic                own;
   logic                timed_out;

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      to_d      = to_q;
      tcnt_d    = tcnt_q;
      s_cyc_d   = s_cyc_q;
      s_stb_d   = s_stb_q;
      s_we_d    = s_we_q;
      s_sel_d   = s_sel_q;
      s_adr_d   = s_adr_q;
      s_dat_d   = s_dat_q;
      grant_d   = grant_q;
      m_ack_d   = m_ack_q;
      m_err_d   = m_err_q;
      m_dat_d   = m_dat_q;

      req       = m_cyc_i & m_stb_i;
      // On a tie the master that was not served last wins.
      pick      = (req == 2'b11) ? ~last_q : req[1];
      own       = grant_q[1];
      timed_out = (to_q == TO_LAST);

      case (state_q)
         IDLE: begin
            if (|req) begin
               state_d = BUSY;
               last_d  = pick;
               grant_d = pick ? 2'b10 : 2'b01;
               s_cyc_d = 1'b1;
               s_stb_d = 1'b1;
               s_we_d  = pick ? m_we_i[1]       : m_we_i[0];
               s_sel_d = pick ? m_sel_i[7:4]    : m_sel_i[3:0];
               s_adr_d = pick ? m_adr_i[63:32]  : m_adr_i[31:0];
               s_dat_d = pick ? m_dat_i[63:32]  : m_dat_i[31:0];
               to_d    = '0;
            end
         end
         BUSY: begin
            if (!m_cyc_i[own]) begin
               state_d = IDLE;
               s_cyc_d = 1'b0;
               s_stb_d = 1'b0;
               grant_d = 2'b00;
            end else if (s_ack_i || s_err_i || timed_out) begin
               state_d = RESP;
               s_cyc_d = 1'b0;
               s_stb_d = 1'b0;
               // A real slave answer beats the timeout; ack with err is an error.
               if (s_err_i) begin
                  m_err_d = grant_q;
               end else if (s_ack_i) begin
                  m_ack_d = grant_q;
                  m_dat_d = s_dat_i;
               end else begin
                  m_err_d = grant_q;
                  if (tcnt_q != '1) tcnt_d = tcnt_q + 1'b1;
               end
            end else begin
               to_d = to_q + 16'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
            grant_d = 2'b00;
            m_ack_d = 2'b00;
            m_err_d = 2'b00;
            m_dat_d = '0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         to_q    <= '0;
         tcnt_q  <= '0;
         s_cyc_q <= 1'b0;
         s_stb_q <= 1'b0;
         s_we_q  <= 1'b0;
         s_sel_q <= '0;
         s_adr_q <= '0;
         s_dat_q <= '0;
         grant_q <= '0;
         m_ack_q <= '0;
         m_err_q <= '0;
         m_dat_q <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         to_q    <= to_d;
         tcnt_q  <= tcnt_d;
         s_cyc_q <= s_cyc_d;
         s_stb_q <= s_stb_d;
         s_we_q  <= s_we_d;
         s_sel_q <= s_sel_d;
         s_adr_q <= s_adr_d;
         s_dat_q <= s_dat_d;
         grant_q <= grant_d;
         m_ack_q <= m_ack_d;
         m_err_q <= m_err_d;
         m_dat_q <= m_dat_d;
      end
   end

   assign m_dat_o       = m_dat_q;
   assign m_ack_o       = m_ack_q;
   assign m_err_o       = m_err_q;
   assign s_cyc_o       = s_cyc_q;
   assign s_stb_o       = s_stb_q;
   assign s_we_o        = s_we_q;
   assign s_sel_o       = s_sel_q;
   assign s_adr_o       = s_adr_q;
   assign s_dat_o       = s_dat_q;
   assign grant_o       = grant_q;
   assign timeout_cnt_o = tcnt_q;

endmodule

// File: tb/tb_wb_sys_arbiter.sv
// Directed bench for wb_sys_arbiter built with an 8-cycle timeout.
module tb_wb_sys_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  m_cyc = '0, m_stb = '0, m_we = '0;
   logic [7:0]  m_sel = '0;
   logic [63:0] m_adr = '0, m_dat = '0;
   logic [31:0] m_dat_o;
   logic [1:0]  m_ack_o, m_err_o, grant_o;
   logic        s_cyc_o, s_stb_o, s_we_o;
   logic [3:0]  s_sel_o;
   logic [31:0] s_adr_o, s_dat_o;
   logic [31:0] s_dat = '0;
   logic        s_ack = 1'b0, s_err = 1'b0;
   logic [15:0] tcnt_o;

   int tests = 0;
   int fails = 0;

   wb_sys_arbiter #(.TIMEOUT(8), .TO_CNT_W(16)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_sel_i(m_sel),
      .m_adr_i(m_adr), .m_dat_i(m_dat), .m_dat_o(m_dat_o),
      .m_ack_o(m_ack_o), .m_err_o(m_err_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat),
      .s_ack_i(s_ack), .s_err_i(s_err),
      .grant_o(grant_o), .timeout_cnt_o(tcnt_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick();
      tick();
      tests++; if (grant_o !== 2'b00) begin fails++; $display("FAIL reset_grant got %h want 0", grant_o); end
      tests++; if ({s_cyc_o, s_stb_o} !== 2'b00) begin fails++; $display("FAIL reset_cyc_stb got %b want 00", {s_cyc_o, s_stb_o}); end
      tests++; if ({m_ack_o, m_err_o} !== 4'b0000) begin fails++; $display("FAIL reset_ack_err got %b want 0000", {m_ack_o, m_err_o}); end
      tests++; if (tcnt_o !== 16'd0 || m_dat_o !== 32'd0) begin fails++; $display("FAIL reset_cnt_dat got %h/%h want 0/0", tcnt_o, m_dat_o); end
      rst = 1'b0;
   endtask

   task automatic test_read;
      m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b00; m_sel = 8'h0F; m_adr = {32'h0, 32'h10};
      tick();
      tests++; if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b110) begin fails++; $display("FAIL read_strobe got %b want 110", {s_cyc_o, s_stb_o, s_we_o}); end
      tests++; if (s_adr_o !== 32'h10 || s_sel_o !== 4'hF) begin fails++; $display("FAIL read_adr got %h/%h want 10/f", s_adr_o, s_sel_o); end
      tests++; if (grant_o !== 2'b01) begin fails++; $display("FAIL read_grant got %b want 01", grant_o); end
      tick();
      tests++; if (s_stb_o !== 1'b1 || s_adr_o !== 32'h10 || m_ack_o !== 2'b00) begin fails++; $display("FAIL read_hold got stb=%b adr=%h ack=%b want 1/10/00", s_stb_o, s_adr_o, m_ack_o); end
      s_ack = 1'b1; s_dat = 32'hDEADBEEF;
      tick();
      s_ack = 1'b0; s_dat = 32'h0;
      m_cyc = 2'b00; m_stb = 2'b00;
      tests++; if (m_ack_o !== 2'b01 || m_err_o !== 2'b00) begin fails++; $display("FAIL read_ack got ack=%b err=%b want 01/00", m_ack_o, m_err_o); end
      tests++; if (m_dat_o !== 32'hDEADBEEF) begin fails++; $display("FAIL read_data got %h want deadbeef", m_dat_o); end
      tests++; if (s_stb_o !== 1'b0 || grant_o !== 2'b01) begin fails++; $display("FAIL read_resp got stb=%b grant=%b want 0/01", s_stb_o, grant_o); end
      tick();
      tests++; if (m_ack_o !== 2'b00 || m_dat_o !== 32'h0 || grant_o !== 2'b00) begin fails++; $display("FAIL read_end got ack=%b dat=%h grant=%b want 00/0/00", m_ack_o, m_dat_o, grant_o); end
   endtask

   task automatic test_round_robin;
      logic [1:0] exp_g [4];
      exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
      do_reset();
      m_adr = {32'h200, 32'h100}; m_sel = 8'h3C;
      m_cyc = 2'b11; m_stb = 2'b11;
      for (int i = 0; i < 4; i++) begin
         tick();
         tests++; if (grant_o !== exp_g[i]) begin fails++; $display("FAIL rr_grant[%0d] got %b want %b", i, grant_o, exp_g[i]); end
         tests++; if (s_adr_o !== (exp_g[i][1] ? 32'h200 : 32'h100)) begin fails++; $display("FAIL rr_adr[%0d] got %h", i, s_adr_o); end
         s_ack = 1'b1; s_dat = 32'hA0 + i;
         tick();
         s_ack = 1'b0;
         tests++; if (m_ack_o !== exp_g[i] || m_dat_o !== 32'hA0 + i) begin fails++; $display("FAIL rr_ack[%0d] got %b/%h want %b/%h", i, m_ack_o, m_dat_o, exp_g[i], 32'hA0 + i); end
         tick();
      end
      m_cyc = 2'b00; m_stb = 2'b00;
      tick();
   endtask

   task automatic test_timeout;
      int n = 0;
      m_cyc = 2'b01; m_stb = 2'b01; m_adr = {32'h0, 32'h44};
      tick();
      for (int i = 0; i < 20; i++) begin
         if (s_stb_o !== 1'b1) break;
         n++;
         tick();
      end
      tests++; if (n != 8) begin fails++; $display("FAIL to_len got %0d want 8", n); end
      tests++; if (m_err_o !== 2'b01 || m_ack_o !== 2'b00) begin fails++; $display("FAIL to_err got err=%b ack=%b want 01/00", m_err_o, m_ack_o); end
      tests++; if (tcnt_o !== 16'd1) begin fails++; $display("FAIL to_count got %0d want 1", tcnt_o); end
      m_cyc = 2'b00; m_stb = 2'b00;
      tick();
      tests++; if (m_err_o !== 2'b00 || grant_o !== 2'b00) begin fails++; $display("FAIL to_end got err=%b grant=%b want 00/00", m_err_o, grant_o); end
   endtask

   task automatic test_ack_err;
      s_ack = 1'b1; s_err = 1'b1;
      tick();
      tick();
      s_ack = 1'b0; s_err = 1'b0;
      tests++; if ({m_ack_o, m_err_o, s_stb_o} !== 5'b0) begin fails++; $display("FAIL idle_ignore got ack=%b err=%b stb=%b want 0", m_ack_o, m_err_o, s_stb_o); end
      m_cyc = 2'b10; m_stb = 2'b10; m_adr = {32'h300, 32'h0};
      tick();
      s_ack = 1'b1; s_err = 1'b1; s_dat = 32'h5555_AAAA;
      tick();
      s_ack = 1'b0; s_err = 1'b0;
      m_cyc = 2'b00; m_stb = 2'b00;
      tests++; if (m_err_o !== 2'b10 || m_ack_o !== 2'b00 || m_dat_o !== 32'h0) begin fails++; $display("FAIL both_err got err=%b ack=%b dat=%h want 10/00/0", m_err_o, m_ack_o, m_dat_o); end
      tests++; if (tcnt_o !== 16'd1) begin fails++; $display("FAIL both_cnt got %0d want 1", tcnt_o); end
      tick();
   endtask

   task automatic test_abort;
      m_cyc = 2'b10; m_stb = 2'b10; m_adr = {32'h400, 32'h500};
      tick();
      tests++; if (grant_o !== 2'b10) begin fails++; $display("FAIL abort_grant1 got %b want 10", grant_o); end
      m_cyc = 2'b01; m_stb = 2'b01;
      tick();
      tests++; if ({s_cyc_o, s_stb_o} !== 2'b00 || grant_o !== 2'b00) begin fails++; $display("FAIL abort_drop got cyc/stb=%b grant=%b want 00/00", {s_cyc_o, s_stb_o}, grant_o); end
      tests++; if ({m_ack_o, m_err_o} !== 4'b0) begin fails++; $display("FAIL abort_noresp got %b want 0", {m_ack_o, m_err_o}); end
      tick();
      tests++; if (grant_o !== 2'b01 || s_adr_o !== 32'h500 || s_stb_o !== 1'b1) begin fails++; $display("FAIL abort_next got grant=%b adr=%h stb=%b want 01/500/1", grant_o, s_adr_o, s_stb_o); end
      s_ack = 1'b1; s_dat = 32'h0BAD_F00D;
      tick();
      s_ack = 1'b0;
      m_cyc = 2'b00; m_stb = 2'b00;
      tests++; if (m_ack_o !== 2'b01 || tcnt_o !== 16'd1) begin fails++; $display("FAIL abort_m0_ack got ack=%b cnt=%0d want 01/1", m_ack_o, tcnt_o); end
      tick();
   endtask

   task automatic test_reset_mid;
      m_cyc = 2'b01; m_stb = 2'b01; m_adr = {32'h0, 32'h600};
      tick();
      tests++; if (s_stb_o !== 1'b1) begin fails++; $display("FAIL rmid_busy got stb=%b want 1", s_stb_o); end
      #2 rst = 1'b1;
      #1;
      tests++; if ({s_cyc_o, s_stb_o} !== 2'b00 || grant_o !== 2'b00) begin fails++; $display("FAIL rmid_async got cyc/stb=%b grant=%b want 00/00", {s_cyc_o, s_stb_o}, grant_o); end
      tests++; if (tcnt_o !== 16'd0 || s_adr_o !== 32'h0 || {m_ack_o, m_err_o} !== 4'b0) begin fails++; $display("FAIL rmid_zero got cnt=%0d adr=%h resp=%b want 0", tcnt_o, s_adr_o, {m_ack_o, m_err_o}); end
      tick();
      rst = 1'b0;
      tick();
      tests++; if (grant_o !== 2'b01 || s_adr_o !== 32'h600) begin fails++; $display("FAIL rmid_regrant got grant=%b adr=%h want 01/600", grant_o, s_adr_o); end
      s_ack = 1'b1; s_dat = 32'h1234_5678;
      tick();
      s_ack = 1'b0;
      m_cyc = 2'b00; m_stb = 2'b00;
      tests++; if (m_ack_o !== 2'b01 || m_dat_o !== 32'h1234_5678) begin fails++; $display("FAIL rmid_ack got ack=%b dat=%h want 01/12345678", m_ack_o, m_dat_o); end
      tick();
   endtask

   initial begin
      test_reset();
      test_read();
      test_round_robin();
      test_timeout();
      test_ack_err();
      test_abort();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/wb_sys_arbiter.md
WB_SYS_ARBITER -- requirements
Module: wb_sys_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024, meaning slave cycles allowed per transfer before forced error (range 2..65535).
REQ-002 SHALL have parameter TO_CNT_W, default 16, meaning width of timeout event counter.
REQ-003 SHALL have one clock and one reset; the reset is asynchronous and active-high.
REQ-004 SHALL have wb_clk_i  input  1  sole clock, all logic rising-edge.
REQ-005 SHALL have wb_rst_i  input  1  asynchronous active-high reset.
REQ-006 SHALL have m_cyc_i  input  2  per-master cycle (bit n = master n).
REQ-007 SHALL have m_stb_i  input  2  per-master strobe.
REQ-008 SHALL have m_we_i  input  2  per-master write enable.
REQ-009 SHALL have m_sel_i  input  8  byte selects, master n at [4n+3:4n].
REQ-010 SHALL have m_adr_i  input  64  addresses, master n at [32n+31:32n].
REQ-011 SHALL have m_dat_i  input  64  write data, same packing.
REQ-012 SHALL have m_dat_o  output  32  read data, shared by both masters.
REQ-013 SHALL have m_ack_o  output  2  per-master acknowledge.
REQ-014 SHALL have m_err_o  output  2  per-master error.
REQ-015 SHALL have s_cyc_o, s_stb_o, s_we_o  output  1 each  slave cycle/strobe/write.
REQ-016 SHALL have s_sel_o  output  4 ; s_adr_o, s_dat_o  output  32  slave select/address/write data.
REQ-017 SHALL have s_dat_i  input  32 ; s_ack_i, s_err_i  input  1  slave read data/ack/error.
REQ-018 SHALL have grant_o  output  2  one-hot current owner, 0 when idle.
REQ-019 SHALL have timeout_cnt_o  output  TO_CNT_W  count of timed-out transfers.

Function
REQ-020 SHALL implement states IDLE, BUSY, RESP; all outputs registered.
REQ-021 Request n SHALL be m_cyc_i[n] & m_stb_i[n], sampled only in IDLE.
REQ-022 IDLE with any request SHALL go BUSY next edge: latch owner's we/sel/adr/dat onto s_*, set s_cyc_o=s_stb_o=1, grant_o one-hot.
REQ-023 Both requesting SHALL grant master not granted last (round-robin pointer updated on every grant).
REQ-024 Latency: request sampled at edge N -> s_stb_o high after edge N.
REQ-025 BUSY SHALL hold all s_* outputs stable until termination.
REQ-026 Termination in BUSY: s_ack_i, s_err_i, or timeout counter reaching TIMEOUT-1 -> next edge: s_cyc_o=s_stb_o=0, go RESP.
REQ-027 RESP SHALL last exactly one cycle: owner's m_ack_o (slave ack) or m_err_o (slave err or timeout) high, m_dat_o = s_dat_i captured at termination edge; then IDLE, grant_o=0.
REQ-028 m_dat_o SHALL be 0 whenever m_ack_o is 0; non-owner ack/err SHALL stay 0.
REQ-029 s_ack_i and s_err_i together SHALL yield err; ack/err arriving on the timeout cycle SHALL take precedence over timeout.
REQ-030 Timeout counter SHALL clear on entering BUSY, increment each BUSY cycle.
REQ-031 Each timeout SHALL increment timeout_cnt_o, saturating at all-ones.
REQ-032 Owner's m_cyc_i low during BUSY SHALL abort: next edge s_cyc_o=s_stb_o=0, no ack/err, go IDLE, no timeout count.
REQ-033 Minimum transfer-to-transfer spacing SHALL be one IDLE cycle after RESP; the waiting master SHALL be granted from that IDLE.
REQ-034 s_ack_i/s_err_i outside BUSY SHALL be ignored.

Reset
REQ-035 wb_rst_i high SHALL immediately force IDLE, all outputs 0, timeout counter 0, timeout_cnt_o 0, pointer so master 0 wins first tie.
REQ-036 Reset mid-transfer SHALL drop s_cyc_o/s_stb_o without issuing ack/err; first post-reset edge sees IDLE.

Verification
REQ-037 M0 read adr 0x10, slave acks 2 cycles after s_stb_o with 0xDEADBEEF -> m_ack_o=01 one cycle, m_dat_o=0xDEADBEEF, grant_o 01 then 00.
REQ-038 Both request simultaneously after reset, repeated 4 transfers -> grant order M0,M1,M0,M1.
REQ-039 TIMEOUT=8, slave never acks -> s_stb_o high 8 cycles, m_err_o pulse to owner, timeout_cnt_o=1.
REQ-040 s_ack_i and s_err_i same cycle -> m_err_o pulse, m_ack_o stays 0.
REQ-041 M1 drops m_cyc_i in BUSY -> s_cyc_o low next edge, no ack/err, M0 pending granted from following IDLE.
REQ-042 wb_rst_i asserted mid-BUSY -> all outputs 0 without waiting for clock edge, normal transfer succeeds after release.
